// File: rtl/serial_link_arbiter.sv
`timescale 1ns/1ps
// serial_link_arbiter: round-robin owner of one serial deserializer link shared by N byte requesters.
// Each transaction sends the granted byte (preamble + 8 bits LSB first) and checks what comes back.
module serial_link_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic           clock_100KHz,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [N-1:0]   err,
    output logic [7:0]     rx_byte,
    output logic           busy,
    output logic           des_write,
    output logic           des_data,
    output logic           des_ack,
    input  logic           des_status,
    input  logic           des_ready,
    input  logic [7:0]     des_byte
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, FLUSH, PRE, SHIFT, WAIT_RDY, ACK, RELEASE, DONE_ERR} state_t;

    state_t        state, state_next;
    logic [PW-1:0] ptr, gidx, sel_idx, idx;
    logic [7:0]    lane [N];
    logic [7:0]    sel_byte, shift, cmp;
    logic [2:0]    cnt;
    logic [TW-1:0] timer;
    logic          sel_found, rel_first, finish;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane[i] = req_data[8*i +: 8];
    end

    // Later iterations win, so walking k downward leaves the first request at or after ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_byte  = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
                sel_byte  = lane[idx];
            end
        end
    end

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = des_ready ? FLUSH : (!des_status && sel_found) ? PRE : IDLE;
            FLUSH:    state_next = IDLE;
            PRE:      state_next = SHIFT;
            SHIFT:    state_next = (cnt == 3'd7) ? WAIT_RDY : SHIFT;
            WAIT_RDY: state_next = des_ready ? ACK : (timer == TW'(TIMEOUT - 1)) ? DONE_ERR : WAIT_RDY;
            ACK:      state_next = RELEASE;
            RELEASE:  state_next = des_ready ? RELEASE : IDLE;
            DONE_ERR: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign finish = (state == RELEASE && !des_ready) || state == DONE_ERR;

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            gidx      <= '0;
            grant     <= '0;
            shift     <= '0;
            cmp       <= '0;
            cnt       <= '0;
            timer     <= '0;
            rx_byte   <= '0;
            rel_first <= 1'b0;
        end else begin
            if (state == IDLE && state_next == PRE) begin
                shift <= sel_byte;
                cmp   <= sel_byte;
                grant <= N'(1) << sel_idx;
                gidx  <= sel_idx;
            end
            if (state == PRE) begin
                cnt   <= '0;
                timer <= '0;
            end
            if (state == SHIFT) begin
                shift <= shift >> 1;
                cnt   <= cnt + 3'd1;
            end
            if (state == WAIT_RDY) begin
                timer <= timer + 1'b1;
                if (des_ready) rx_byte <= des_byte;
            end
            if (finish) begin
                grant <= '0;
                ptr   <= PW'((int'(gidx) + 1) % N);
            end
            rel_first <= state == ACK;
        end
    end

    always_comb begin
        busy      = state != IDLE;
        des_write = state == PRE || state == SHIFT;
        des_data  = state == SHIFT && shift[0];
        des_ack   = state == FLUSH || state == ACK;
        done      = ((state == RELEASE && rel_first) || state == DONE_ERR) ? grant : '0;
        err       = (state == DONE_ERR || (state == RELEASE && rel_first && rx_byte != cmp)) ? grant : '0;
    end
endmodule
